hud_border_overlay: RTL and testbench
=====================================

Name: hud_border_overlay

Overview:
Parametrised playfield border and HUD timer renderer for the VGA pipeline.
- Per pixel, selects one of three sources: border colour, an N-digit BCD timer drawn from a glyph ROM, or the game-layer pixel.
- Sits between the game renderer and the VGA output stage.
- Adds frame-synchronised timer snapshotting and a low-time blink/expired warning mode.

Parameters:
DIGITS, 3, number of BCD timer digits; MS digit leftmost.
BORDER_W, 8, border thickness in pixels on all four edges.
DIGIT_W, 8, glyph cell width in pixels.
DIGIT_H, 16, glyph cell height in pixels.
BORDER_COLOUR, 16'h5746, RGB565 border colour.
DIGIT_FG, 16'hFFFF, glyph foreground colour.
DIGIT_BG, 16'h0000, glyph cell background colour.
WARN_COLOUR, 16'hF800, foreground colour while warning.
WARN_THRESH, 10, timer value (decimal) at or below which warning starts.
BLINK_FRAMES, 30, frames per blink half-period.

Ports:
vga_clk  input  1  pixel clock
sys_rst_n  input  1  asynchronous active-low reset
pix_x  input  10  current pixel column
pix_y  input  10  current pixel row
pix_valid  input  1  pix_x/pix_y lie in the active area
game_pix  input  16  game-layer RGB565 pixel for pix_x/pix_y
frame_start  input  1  one-cycle pulse before the first active pixel of a frame
time_bcd  input  4*DIGITS  live timer, BCD, MS digit in top nibble
pix_data  output  16  composited RGB565 pixel
pix_data_valid  output  1  pix_valid delayed to align with pix_data
warn_active  output  1  high in BLINK_ON, BLINK_OFF or EXPIRED

Behaviour:
- Clock and reset: single clock vga_clk; reset sys_rst_n is asynchronous, active-low.
- Reset values: pix_data=0, pix_data_valid=0, warn_active=0, FSM=NORMAL, snapshot=0, frame counter=0. Reset mid-frame flushes the pipeline immediately; output resumes with the next valid pixel after release.
- Latency: fixed 2 cycles from pix_x/pix_y/pix_valid/game_pix to pix_data/pix_data_valid, with no bubbles.
  - Stage 1 registers the region class, digit index, glyph column and game_pix. The ROM address is formed combinationally from the inputs; the ROM read is synchronous.
  - Stage 2 selects the glyph bit, applies the colour mux and registers pix_data.
- Snapshot: time_bcd is captured only on frame_start, so no tearing occurs mid-frame. If time_bcd changes in the same cycle as frame_start, the new value is captured.
- Digit field:
  - Rows VGA_HEIGHT-DIGIT_H .. VGA_HEIGHT-1.
  - Columns start at VGA_WIDTH/2 - (DIGITS*DIGIT_W)/2 and span DIGITS*DIGIT_W.
  - The digit field has priority over the border.
- Border: pix_x<BORDER_W, or pix_x>=VGA_WIDTH-BORDER_W, or pix_y<BORDER_W, or pix_y>=VGA_HEIGHT-BORDER_W.
- Otherwise the output is game_pix.
- Glyph pixel colour:
  - Set bit -> foreground: DIGIT_FG in NORMAL and BLINK_ON, WARN_COLOUR in EXPIRED, DIGIT_BG in BLINK_OFF.
  - Clear bit -> DIGIT_BG.
  - BCD nibble >9 is rendered as a blank cell (all DIGIT_BG).
- pix_valid low -> pix_data=0 two cycles later.
- Warning FSM (evaluated only on frame_start, using the value being snapshotted):
  - NORMAL -> BLINK_ON when 0 < value <= WARN_THRESH.
  - Any state -> EXPIRED when value == 0.
  - Any state -> NORMAL when value > WARN_THRESH.
  - BLINK_ON <-> BLINK_OFF toggle when frame counter == BLINK_FRAMES-1. The counter then wraps to 0; it is cleared on entering NORMAL or EXPIRED.
- Value conversion: BCD to binary via a DIGITS-wide weighted sum; 14 bits is sufficient for DIGITS<=4.
- Elaboration constraint: DIGITS*DIGIT_W <= VGA_WIDTH-2*BORDER_W.

Optional Feature:
HUD_LEADING_ZERO_BLANK_EN
- Defined: leading zero digits render as blank cells. The least-significant digit is always drawn, so 007 displays as "  7".
- Undefined: all digits are drawn, including leading zeros.

Decomposition:
- Shared define.vh: VGA_WIDTH, VGA_HEIGHT, RGB565 colour constants, warning FSM state encodings (NORMAL, BLINK_ON, BLINK_OFF, EXPIRED), region-class encodings.
- Sub-module digit_glyph_rom:
  - Inputs: 4-bit digit and 4-bit row.
  - Output: DIGIT_W-bit row bitmap, 1-cycle synchronous read.
  - Codes 10..15 return all zeros.

Test Plan:
1. Reset held mid-line, then released with pix_x=0, pix_y=0, pix_valid=1 -> pix_data=16'h5746 exactly 2 cycles after the first post-release input; all outputs 0 while reset is held.
2. time_bcd=12'h123 captured on frame_start; scan the digit-field row at glyph row 8 -> pixels match ROM bitmaps for 1,2,3 in DIGIT_FG/DIGIT_BG. Change time_bcd to 12'h456 mid-frame -> display unchanged until the next frame_start.
3. Pixel (320,240) with game_pix=16'h1234 -> pix_data=16'h1234. Pixel (3,240) -> 16'h5746. Pixel at the digit-field column start, row 479 -> digit-field colour, not the border colour.
4. time_bcd=12'h010 on frame_start -> warn_active=1, BLINK_ON. After 30 frame_starts -> BLINK_OFF, glyphs all DIGIT_BG. After 30 more -> BLINK_ON.
5. time_bcd=12'h000 -> EXPIRED, glyph foreground 16'hF800, no blinking. time_bcd=12'h120 -> NORMAL, warn_active=0.
6. time_bcd=12'h0A7 -> middle cell blank. With HUD_LEADING_ZERO_BLANK_EN defined, 12'h007 -> cells 0-1 blank, cell 2 shows 7.

Source files
------------

// File: rtl/hud_border_overlay_pkg.sv
// Shared definitions for the HUD border/timer overlay: screen geometry, RGB565
// colours, warning FSM and region encodings, and the seven-segment digit font.
package hud_border_overlay_pkg;

    localparam int unsigned VGA_WIDTH  = 640;
    localparam int unsigned VGA_HEIGHT = 480;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_SAGE  = 16'h5746;

    typedef enum logic [1:0] {
        StNormal   = 2'd0,
        StBlinkOn  = 2'd1,
        StBlinkOff = 2'd2,
        StExpired  = 2'd3
    } warn_state_e;

    typedef enum logic [1:0] {
        RegGame   = 2'd0,
        RegBorder = 2'd1,
        RegDigit  = 2'd2
    } region_e;

    // 8x16 seven-segment font, MSB is the leftmost column. Segment bits are
    // gfedcba; horizontal bars sit on rows 1/7/14, vertical bars on cols 1/6.
    function automatic logic [7:0] glyph_row(input logic [3:0] digit, input logic [3:0] row);
        logic [6:0] seg;
        logic [7:0] bits;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        bits = 8'h00;
        if (seg[0] && row == 4'd1)  bits = bits | 8'h7E;
        if (seg[6] && row == 4'd7)  bits = bits | 8'h7E;
        if (seg[3] && row == 4'd14) bits = bits | 8'h7E;
        if (seg[5] && row >= 4'd1 && row <= 4'd7)  bits = bits | 8'h40;
        if (seg[1] && row >= 4'd1 && row <= 4'd7)  bits = bits | 8'h02;
        if (seg[4] && row >= 4'd7 && row <= 4'd14) bits = bits | 8'h40;
        if (seg[2] && row >= 4'd7 && row <= 4'd14) bits = bits | 8'h02;
        return bits;
    endfunction

endpackage

// File: rtl/hud_border_overlay_if.sv
// Pixel stream and timer bus between the game renderer, the overlay and the
// VGA output stage. The master drives coordinates/pixels, the overlay is slave.
interface hud_border_overlay_if #(
    parameter int unsigned DIGITS = 3
);
    logic [9:0]          pix_x;
    logic [9:0]          pix_y;
    logic                pix_valid;
    logic [15:0]         game_pix;
    logic                frame_start;
    logic [4*DIGITS-1:0] time_bcd;
    logic [15:0]         pix_data;
    logic                pix_data_valid;
    logic                warn_active;

    modport master (
        output pix_x, pix_y, pix_valid, game_pix, frame_start, time_bcd,
        input  pix_data, pix_data_valid, warn_active
    );

    modport slave (
        input  pix_x, pix_y, pix_valid, game_pix, frame_start, time_bcd,
        output pix_data, pix_data_valid, warn_active
    );
endinterface

// File: rtl/hud_border_overlay_digit_glyph_rom.sv
// Digit glyph ROM: one DIGIT_W-wide row bitmap per (digit, row), registered
// read. Codes 10..15 are blank, which the overlay also uses to force a blank cell.
module hud_border_overlay_digit_glyph_rom
    import hud_border_overlay_pkg::*;
#(
    parameter int unsigned DIGIT_W = 8
) (
    input  logic               vga_clk,
    input  logic               sys_rst_n,
    input  logic [3:0]         digit,
    input  logic [3:0]         row,
    output logic [DIGIT_W-1:0] bitmap
);

    logic [7:0]         font_row;
    logic [DIGIT_W-1:0] scaled_row;

    assign font_row = glyph_row(digit, row);

    // Stretch or squeeze the 8-column font to the cell width (identity for 8).
    for (genvar c = 0; c < DIGIT_W; c++) begin : g_col
        assign scaled_row[DIGIT_W-1-c] = font_row[7 - (c * 8) / DIGIT_W];
    end

    // Synchronous ROM read.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bitmap <= '0;
        end else begin
            bitmap <= scaled_row;
        end
    end

endmodule

// File: rtl/hud_border_overlay.sv
// Playfield border and BCD timer HUD compositor. Two-stage pixel pipeline:
// stage 1 classifies the pixel and reads the glyph ROM, stage 2 colours it.
// Optional build macro HUD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module hud_border_overlay
    import hud_border_overlay_pkg::*;
#(
    parameter int unsigned DIGITS        = 3,
    parameter int unsigned BORDER_W      = 8,
    parameter int unsigned DIGIT_W       = 8,
    parameter int unsigned DIGIT_H       = 16,
    parameter logic [15:0] BORDER_COLOUR = RGB565_SAGE,
    parameter logic [15:0] DIGIT_FG      = RGB565_WHITE,
    parameter logic [15:0] DIGIT_BG      = RGB565_BLACK,
    parameter logic [15:0] WARN_COLOUR   = RGB565_RED,
    parameter int unsigned WARN_THRESH   = 10,
    parameter int unsigned BLINK_FRAMES  = 30
) (
    input logic               vga_clk,
    input logic               sys_rst_n,
    hud_border_overlay_if.slave bus
);

    localparam int unsigned FIELD_W = DIGITS * DIGIT_W;
    localparam logic [9:0] FIELD_X0 = 10'(VGA_WIDTH / 2 - FIELD_W / 2);
    localparam logic [9:0] FIELD_X1 = 10'(VGA_WIDTH / 2 - FIELD_W / 2 + FIELD_W);
    localparam logic [9:0] FIELD_Y0 = 10'(VGA_HEIGHT - DIGIT_H);
    localparam logic [9:0] SCREEN_H = 10'(VGA_HEIGHT);
    localparam logic [9:0] BORDER_L = 10'(BORDER_W);
    localparam logic [9:0] BORDER_R = 10'(VGA_WIDTH - BORDER_W);
    localparam logic [9:0] BORDER_B = 10'(VGA_HEIGHT - BORDER_W);
    localparam int unsigned COL_W = (DIGIT_W > 1) ? $clog2(DIGIT_W) : 1;
    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [13:0] THRESH = 14'(WARN_THRESH);

    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
        $error("DIGITS must be 1..4 for the 14-bit timer value");
    end
    if (FIELD_W > VGA_WIDTH - 2 * BORDER_W) begin : g_bad_field
        $error("digit field wider than the playfield");
    end

    logic [4*DIGITS-1:0] snap_q;
    logic [13:0]         live_val;
    warn_state_e         state_q;
    logic [CNT_W-1:0]    frame_cnt_q;
    logic                warn_q;

    logic                in_field;
    logic                in_border;
    region_e             region_d;
    logic [9:0]          dx;
    logic [9:0]          dy;
    logic [9:0]          digit_idx;
    logic [COL_W-1:0]    glyph_col;
    logic [3:0]          glyph_rrow;
    logic [3:0]          nib;
    logic [3:0]          rom_digit;
`ifdef HUD_LEADING_ZERO_BLANK_EN
    logic                zero_run;
`endif

    region_e             region_q;
    logic [COL_W-1:0]    col_q;
    logic [15:0]         game_q;
    logic                valid_q;
    logic [DIGIT_W-1:0]  glyph_bits;

    logic [COL_W-1:0]    bit_sel;
    logic                glyph_bit;
    logic [15:0]         fg;
    logic [15:0]         pix_d;
    logic [15:0]         pix_data_q;
    logic                pix_valid_q;

    // Weighted BCD-to-binary of the live timer; evaluated when it is snapshotted.
    always_comb begin
        live_val = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            live_val = (live_val * 14'd10) + {10'd0, bus.time_bcd[4*i +: 4]};
        end
    end

    // Snapshot the timer once per frame so the display never tears mid-frame.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            snap_q <= '0;
        end else if (bus.frame_start) begin
            snap_q <= bus.time_bcd;
        end
    end

    // Warning FSM with blink counter; advances only on frame_start.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StNormal;
            frame_cnt_q <= '0;
            warn_q      <= 1'b0;
        end else if (bus.frame_start) begin
            if (live_val == 14'd0) begin
                state_q     <= StExpired;
                frame_cnt_q <= '0;
                warn_q      <= 1'b1;
            end else if (live_val > THRESH) begin
                state_q     <= StNormal;
                frame_cnt_q <= '0;
                warn_q      <= 1'b0;
            end else begin
                warn_q <= 1'b1;
                case (state_q)
                    StNormal: begin
                        state_q     <= StBlinkOn;
                        frame_cnt_q <= '0;
                    end
                    StBlinkOn, StBlinkOff: begin
                        if (frame_cnt_q == CNT_LAST) begin
                            state_q     <= (state_q == StBlinkOn) ? StBlinkOff : StBlinkOn;
                            frame_cnt_q <= '0;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        end
                    end
                    default: ;  // EXPIRED holds until zero or above threshold
                endcase
            end
        end
    end

    // Stage 0: region classification and glyph cell coordinates.
    always_comb begin
        dx         = bus.pix_x - FIELD_X0;
        dy         = bus.pix_y - FIELD_Y0;
        digit_idx  = dx / 10'(DIGIT_W);
        glyph_col  = COL_W'(dx % 10'(DIGIT_W));
        glyph_rrow = 4'(({4'd0, dy} << 4) / 14'(DIGIT_H));
        in_field   = (bus.pix_y >= FIELD_Y0) && (bus.pix_y < SCREEN_H) &&
                     (bus.pix_x >= FIELD_X0) && (bus.pix_x < FIELD_X1);
        in_border  = (bus.pix_x < BORDER_L) || (bus.pix_x >= BORDER_R) ||
                     (bus.pix_y < BORDER_L) || (bus.pix_y >= BORDER_B);
        region_d   = RegGame;
        if (in_field) begin
            region_d = RegDigit;
        end else if (in_border) begin
            region_d = RegBorder;
        end
    end

    // Stage 0: pick the snapshot nibble for this cell; code 4'hF means blank.
    always_comb begin
        nib       = '0;
        rom_digit = 4'hF;
`ifdef HUD_LEADING_ZERO_BLANK_EN
        zero_run  = 1'b1;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            nib = snap_q[4*(DIGITS-1-i) +: 4];
`ifdef HUD_LEADING_ZERO_BLANK_EN
            zero_run = zero_run && (nib == 4'd0);
`endif
            if (in_field && digit_idx == 10'(i)) begin
                rom_digit = nib;
`ifdef HUD_LEADING_ZERO_BLANK_EN
                // Least-significant digit is always drawn.
                if (zero_run && i != DIGITS - 1) begin
                    rom_digit = 4'hF;
                end
`endif
            end
        end
    end

    hud_border_overlay_digit_glyph_rom #(
        .DIGIT_W (DIGIT_W)
    ) u_glyph_rom (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .digit     (rom_digit),
        .row       (glyph_rrow),
        .bitmap    (glyph_bits)
    );

    // Stage 1 registers, aligned with the ROM read.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            region_q <= RegGame;
            col_q    <= '0;
            game_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            region_q <= region_d;
            col_q    <= glyph_col;
            game_q   <= bus.game_pix;
            valid_q  <= bus.pix_valid;
        end
    end

    // Stage 2: glyph bit select and colour mux.
    always_comb begin
        bit_sel   = COL_W'(DIGIT_W - 1) - col_q;
        glyph_bit = glyph_bits[bit_sel];
        case (state_q)
            StBlinkOff: fg = DIGIT_BG;
            StExpired:  fg = WARN_COLOUR;
            default:    fg = DIGIT_FG;
        endcase
        pix_d = 16'h0000;
        if (valid_q) begin
            case (region_q)
                RegBorder: pix_d = BORDER_COLOUR;
                RegDigit:  pix_d = glyph_bit ? fg : DIGIT_BG;
                default:   pix_d = game_q;
            endcase
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            pix_data_q  <= pix_d;
            pix_valid_q <= valid_q;
        end
    end

    assign bus.pix_data       = pix_data_q;
    assign bus.pix_data_valid = pix_valid_q;
    assign bus.warn_active    = warn_q;

endmodule

// File: tb/tb_hud_border_overlay.sv
// Self-checking bench for hud_border_overlay: directed scenarios plus random
// pixels, compared against a per-pixel reference model of the overlay rules.
module tb_hud_border_overlay;

    localparam int W   = 640;
    localparam int H   = 480;
    localparam int DIG = 3;
    localparam int BW  = 8;
    localparam int DW  = 8;
    localparam int DH  = 16;
    localparam int FX0 = W / 2 - (DIG * DW) / 2;
    localparam int FY0 = H - DH;

    logic vga_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    always #5 vga_clk = ~vga_clk;

    hud_border_overlay_if #(.DIGITS(DIG)) bus ();

    hud_border_overlay #(
        .DIGITS        (DIG),
        .BORDER_W      (BW),
        .DIGIT_W       (DW),
        .DIGIT_H       (DH),
        .BORDER_COLOUR (16'h5746),
        .DIGIT_FG      (16'hFFFF),
        .DIGIT_BG      (16'h0000),
        .WARN_COLOUR   (16'hF800),
        .WARN_THRESH   (10),
        .BLINK_FRAMES  (30)
    ) dut (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: displayed snapshot, warn mode (0 normal,
    // 1 blink-on, 2 blink-off, 3 expired) and frames spent in the blink phase.
    logic [11:0] m_snap = 12'h000;
    int          m_mode = 0;
    int          m_cnt  = 0;
    logic [16:0] exp_q[$];
    string       tag_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit seg_on(input int d, input int c, input int r);
        bit top, mid, bot, ul, ur, ll, lr, on;
        top = (d != 1) && (d != 4);
        mid = d inside {2, 3, 4, 5, 6, 8, 9};
        bot = d inside {0, 2, 3, 5, 6, 8, 9};
        ul  = d inside {0, 4, 5, 6, 8, 9};
        ur  = d inside {0, 1, 2, 3, 4, 7, 8, 9};
        ll  = d inside {0, 2, 6, 8};
        lr  = (d != 2);
        on  = 1'b0;
        if (c >= 1 && c <= 6 && r == 1 && top) on = 1'b1;
        if (c >= 1 && c <= 6 && r == 7 && mid) on = 1'b1;
        if (c >= 1 && c <= 6 && r == 14 && bot) on = 1'b1;
        if (c == 1 && r >= 1 && r <= 7 && ul) on = 1'b1;
        if (c == 6 && r >= 1 && r <= 7 && ur) on = 1'b1;
        if (c == 1 && r >= 7 && r <= 14 && ll) on = 1'b1;
        if (c == 6 && r >= 7 && r <= 14 && lr) on = 1'b1;
        return on;
    endfunction

    function automatic int snap_digit(input int k);
        return int'((m_snap >> (4 * (DIG - 1 - k))) & 12'h00F);
    endfunction

    function automatic logic [15:0] model_pix(input int x, input int y, input bit v,
                                              input logic [15:0] g);
        int k, c, r, d;
        bit blank;
        logic [15:0] fg;
        if (!v) return 16'h0000;
        if (y >= FY0 && y < H && x >= FX0 && x < FX0 + DIG * DW) begin
            k = (x - FX0) / DW;
            c = (x - FX0) % DW;
            r = y - FY0;
            d = snap_digit(k);
            blank = (d > 9);
`ifdef HUD_LEADING_ZERO_BLANK_EN
            begin
                bit lead = 1'b1;
                for (int j = 0; j <= k; j++) if (snap_digit(j) != 0) lead = 1'b0;
                if (lead && k < DIG - 1) blank = 1'b1;
            end
`endif
            fg = (m_mode == 3) ? 16'hF800 : (m_mode == 2) ? 16'h0000 : 16'hFFFF;
            return (!blank && seg_on(d, c, r)) ? fg : 16'h0000;
        end
        if (x < BW || x >= W - BW || y < BW || y >= H - BW) return 16'h5746;
        return g;
    endfunction

    function automatic void model_frame(input logic [11:0] bcd);
        int val;
        val = int'(bcd[11:8]) * 100 + int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
        m_snap = bcd;
        if (val == 0) begin
            m_mode = 3; m_cnt = 0;
        end else if (val > 10) begin
            m_mode = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_cnt = 0;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (m_cnt == 29) begin
                m_mode = 3 - m_mode; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endfunction

    // Drive one pixel for one cycle; the output seen now belongs to the
    // pixel driven two steps earlier.
    task automatic step(input int x, input int y, input bit v, input logic [15:0] g,
                        input bit fs, input string tag);
        logic [16:0] e;
        string t;
        bus.pix_x       = 10'(x);
        bus.pix_y       = 10'(y);
        bus.pix_valid   = v;
        bus.game_pix    = g;
        bus.frame_start = fs;
        exp_q.push_back({v, model_pix(x, y, v, g)});
        tag_q.push_back(tag);
        if (fs) model_frame(bus.time_bcd);
        @(posedge vga_clk);
        #1;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq({t, "/pix_data"}, 32'(bus.pix_data), 32'(e[15:0]));
            check_eq({t, "/pix_valid"}, 32'(bus.pix_data_valid), 32'(e[16]));
        end
    endtask

    task automatic idle();
        step(0, 0, 1'b0, 16'h0000, 1'b0, "idle");
    endtask

    task automatic new_frame(input logic [11:0] bcd);
        bus.time_bcd = bcd;
        step(0, 0, 1'b0, 16'h0000, 1'b1, "fs");
        check_eq("warn_active", 32'(bus.warn_active), 32'(m_mode != 0));
        idle();
    endtask

    task automatic scan_row(input int y, input string tag);
        for (int x = FX0 - 4; x < FX0 + DIG * DW + 4; x++) begin
            step(x, y, 1'b1, 16'($urandom), 1'b0, tag);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "/pix_data"}, 32'(bus.pix_data), 32'h0);
        check_eq({tag, "/pix_valid"}, 32'(bus.pix_data_valid), 32'h0);
        check_eq({tag, "/warn"}, 32'(bus.warn_active), 32'h0);
    endtask

    // Release reset between edges; the flushed stage-1 contents appear first.
    task automatic release_reset();
        sys_rst_n = 1'b1;
        exp_q.push_back(17'h0);
        tag_q.push_back("rst_flush");
        step(0, 0, 1'b1, 16'($urandom), 1'b0, "post_rst_first_pix");
        idle();
    endtask

    task automatic reset_midline();
        for (int x = 100; x < 104; x++) step(x, 200, 1'b1, 16'($urandom), 1'b0, "pre_rst");
        #3;
        sys_rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        m_snap = 12'h000; m_mode = 0; m_cnt = 0;
        exp_q.delete();
        tag_q.delete();
        for (int i = 0; i < 3; i++) begin
            bus.pix_x     = 10'(50 + i);
            bus.pix_valid = 1'b1;
            bus.game_pix  = 16'($urandom);
            @(posedge vga_clk);
            #1;
            check_reset_outputs("rst_held");
        end
    endtask

    initial begin
        logic [11:0] rb;
        bus.pix_x = '0; bus.pix_y = '0; bus.pix_valid = 1'b1; bus.game_pix = 16'h1111;
        bus.frame_start = 1'b0; bus.time_bcd = 12'h000;

        // Reset held with valid pixels on the bus, then released.
        repeat (3) @(posedge vga_clk);
        #1;
        check_reset_outputs("rst_init");
        release_reset();

        // Snapshot 123, tearing-free mid-frame change, then the new frame.
        new_frame(12'h123);
        scan_row(FY0 + 8, "row8_123");
        bus.time_bcd = 12'h456;
        scan_row(FY0 + 8, "row8_hold");
        scan_row(FY0 + 1, "row1_hold");
        new_frame(12'h456);
        scan_row(FY0 + 8, "row8_456");
        scan_row(FY0 + 14, "row14_456");

        // Region selection and border boundaries.
        step(320, 240, 1'b1, 16'h1234, 1'b0, "game_center");
        step(3, 240, 1'b1, 16'h1234, 1'b0, "border_left");
        step(FX0, 479, 1'b1, 16'h1234, 1'b0, "field_over_border");
        step(7, 9, 1'b1, 16'h2222, 1'b0, "border_x7");
        step(8, 8, 1'b1, 16'h3333, 1'b0, "game_8_8");
        step(631, 100, 1'b1, 16'h4444, 1'b0, "game_x631");
        step(632, 100, 1'b1, 16'h4444, 1'b0, "border_x632");
        step(100, 471, 1'b1, 16'h5555, 1'b0, "game_y471");
        step(100, 472, 1'b1, 16'h5555, 1'b0, "border_y472");
        step(100, 7, 1'b1, 16'h6666, 1'b0, "border_y7");
        step(320, 240, 1'b0, 16'h7777, 1'b0, "invalid_pix");
        idle();

        // Low time: blink on, off after 30 frames, on again after 30 more.
        new_frame(12'h010);
        scan_row(FY0 + 8, "blink_start");
        for (int f = 1; f <= 60; f++) begin
            new_frame(12'h010);
            if (f == 29 || f == 30 || f == 59 || f == 60) scan_row(FY0 + 7, "blink");
            else step(FX0 + 2 * DW + 6, FY0 + 8, 1'b1, 16'h0, 1'b0, "blink_px");
        end

        // Expired does not blink; above threshold returns to normal.
        for (int f = 0; f < 35; f++) begin
            new_frame(12'h000);
            if (f == 0 || f == 31) scan_row(FY0 + 7, "expired");
        end
        new_frame(12'h120);
        scan_row(FY0 + 7, "normal_120");

        // Mid-line reset while warning, then recovery.
        new_frame(12'h005);
        reset_midline();
        release_reset();
        scan_row(FY0 + 8, "after_rst");

        // Invalid nibble and leading zeros.
        new_frame(12'h0A7);
        scan_row(FY0 + 7, "bcd_0A7");
        new_frame(12'h007);
        scan_row(FY0 + 8, "bcd_007");
        scan_row(FY0 + 1, "bcd_007_r1");

        // Random frames and pixels, biased towards the digit field.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                int v = $urandom_range(0, 12);
                rb = {4'd0, 4'(v / 10), 4'(v % 10)};
            end else begin
                rb = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                      4'($urandom_range(0, 11))};
            end
            new_frame(rb);
            for (int p = 0; p < 60; p++) begin
                int x, y;
                if ($urandom_range(0, 1) == 0) begin
                    x = $urandom_range(FX0 - 8, FX0 + DIG * DW + 8);
                    y = $urandom_range(H - DH - 10, H - 1);
                end else begin
                    x = $urandom_range(0, W - 1);
                    y = $urandom_range(0, H - 1);
                end
                if (p == 30) bus.time_bcd = 12'($urandom);
                step(x, y, ($urandom_range(0, 9) != 0), 16'($urandom), 1'b0, "rand");
            end
        end
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
